// File: rtl/shift_tx_ctrl_pkg.sv
// Shared definitions for the shift-register transmit controller: state encoding and width helpers.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package shift_tx_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/shift_tx_ctrl_if.sv
// Upstream word handshake plus shift-register control bundle.
// Latency: n/a (wiring only). Optional FrameCnt signal present when FRAME_CNT_EN is defined.
// Backpressure: Ready low while a frame (load, shift, gap) is in progress.
interface shift_tx_ctrl_if #(
  parameter int SIZE = 8
);
  logic            Valid;
  logic [SIZE-1:0] Data;
  logic            Ready;
  logic            Load;
  logic            En;
  logic [SIZE-1:0] ShData;
  logic            Busy;
  logic            Done;
`ifdef FRAME_CNT_EN
  logic [15:0]     FrameCnt;

  modport master (output Valid, Data,
                  input  Ready, Load, En, ShData, Busy, Done, FrameCnt);
  modport slave  (input  Valid, Data,
                  output Ready, Load, En, ShData, Busy, Done, FrameCnt);
`else
  modport master (output Valid, Data,
                  input  Ready, Load, En, ShData, Busy, Done);
  modport slave  (input  Valid, Data,
                  output Ready, Load, En, ShData, Busy, Done);
`endif
endinterface

// File: rtl/shift_tx_ctrl_bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each period.
// Latency: tick in the DIV-th cycle after clear is released.
// Backpressure: none; free-running unless held in clear.
module bit_tick_gen
  import shift_tx_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = cnt_w(DIV);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == W'(DIV - 1));

  // Divider: restart on clear or at the end of each bit period.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                r_cnt <= '0;
    else if (i_clr || o_tick)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/shift_tx_ctrl.sv
// Serialiser control: accepts a word, pulses Load, then one En per DIV clocks for SIZE bits, then GAP*DIV idle clocks.
// Latency: Load 1 cycle after handshake; Done with last En at 1+SIZE*DIV; Ready back at 2+(SIZE+GAP)*DIV. FRAME_CNT_EN adds FrameCnt.
// Backpressure: Ready only in IDLE; Valid while busy is ignored and the word stays upstream.
module shift_tx_ctrl
  import shift_tx_ctrl_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DIV  = 4,
  parameter int GAP  = 1
) (
  input  logic           Clk,
  input  logic           Rst_n,
  shift_tx_ctrl_if.slave bus
);
  localparam int BW = cnt_w(SIZE + 1);
  localparam int GW = cnt_w(GAP * DIV + 1);

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_shdata;
  logic [BW-1:0]   r_bitcnt;
  logic [GW-1:0]   r_gapcnt;
  logic            w_tick;
  logic            w_clr;
  logic            w_hs;
  logic            w_last_bit;
  logic            w_gap_end;
  logic            w_load;
  logic            w_en;
  logic            w_done;

  assign w_hs       = bus.Valid && (r_state == S_IDLE);
  // Hold the divider at zero until shifting starts so the first bit gets a full period.
  assign w_clr      = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_last_bit = (r_bitcnt == BW'(SIZE - 1));
  assign w_gap_end  = (r_gapcnt == GW'((GAP > 0) ? GAP - 1 : 0));

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and decoded strobes; strobes depend only on registered state/counters.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_en   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.Valid) w_next = S_LOAD;
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_en = w_tick;
        if (w_tick && w_last_bit) begin
          w_done = 1'b1;
          w_next = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP:   if (w_tick && w_gap_end) w_next = S_IDLE;
    endcase
  end

  // Word capture at the handshake edge only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    r_shdata <= '0;
    else if (w_hs) r_shdata <= bus.Data;
  end

  // Bit counter counts En pulses; gap counter counts bit periods spent in GAP.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bitcnt <= '0;
      r_gapcnt <= '0;
    end else begin
      if (r_state == S_LOAD) r_bitcnt <= '0;
      else if (w_en)         r_bitcnt <= r_bitcnt + BW'(1);
      if (r_state != S_GAP)  r_gapcnt <= '0;
      else if (w_tick)       r_gapcnt <= r_gapcnt + GW'(1);
    end
  end

  assign bus.Ready  = (r_state == S_IDLE);
  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.Load   = w_load;
  assign bus.En     = w_en;
  assign bus.Done   = w_done;
  assign bus.ShData = r_shdata;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      r_frame_cnt <= '0;
    else if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign bus.FrameCnt = r_frame_cnt;
`endif
endmodule
